// File: rtl/mvm_axis_loader.sv
// mvm_axis_loader: turns a command plus a word stream into single-beat AXIS packets with packed tuser (clk, rst async active-low; cmd_*, wr_*, axis_rx_*, busy, done)
module mvm_axis_loader #(
  parameter int DATAW = 512,
  parameter int DPES = 64,
  parameter int RFADDRW = 9,
  parameter int USERW = 75,
  parameter int LENW = 7,
  localparam int DPEW = $clog2(DPES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [RFADDRW-1:0] cmd_addr,
  input  logic [DPEW-1:0]    cmd_dpe,
  input  logic [LENW-1:0]    cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATAW-1:0]   wr_data,
  output logic               axis_rx_tvalid,
  output logic [DATAW-1:0]   axis_rx_tdata,
  output logic [USERW-1:0]   axis_rx_tuser,
  output logic               axis_rx_tlast,
  input  logic               axis_rx_tready,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state;
  logic [1:0] op;
  logic [RFADDRW-1:0] addr;
  logic [DPEW-1:0] dpe;
  logic [LENW-1:0] rem;
  logic [DPES-1:0] sel;
  logic take, wr_hs;
  // gating with rst keeps cmd_ready low while reset is held
  assign cmd_ready = rst && state == IDLE;
  assign take = axis_rx_tvalid && axis_rx_tready;
  assign wr_ready = state == STREAM && (!axis_rx_tvalid || axis_rx_tready);
  assign wr_hs = wr_valid && wr_ready;
  always_comb begin
    sel = '0;
    sel[dpe] = op == 2'b11;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      dpe <= '0;
      rem <= '0;
      axis_rx_tvalid <= 1'b0;
      axis_rx_tdata <= '0;
      axis_rx_tuser <= '0;
      axis_rx_tlast <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (take) begin
        axis_rx_tvalid <= 1'b0;
        axis_rx_tlast <= 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        op <= cmd_op;
        addr <= cmd_addr;
        dpe <= cmd_dpe;
        rem <= cmd_op == 2'b11 ? cmd_len : LENW'(1);
        if (cmd_op == 2'b11 && cmd_len == '0) begin
          done <= 1'b1;
        end else begin
          state <= STREAM;
          busy <= 1'b1;
        end
      end
      // a new word may replace the beat being taken in the same cycle
      if (wr_hs) begin
        axis_rx_tvalid <= 1'b1;
        axis_rx_tlast <= 1'b1;
        axis_rx_tdata <= wr_data;
        axis_rx_tuser <= {sel, op, addr};
        dpe <= dpe == DPEW'(DPES - 1) ? '0 : dpe + 1'b1;
        rem <= rem - 1'b1;
        state <= rem == LENW'(1) ? DRAIN : STREAM;
      end
      if (state == DRAIN && take) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mvm_axis_loader.sv
// tb_mvm_axis_loader: directed self-checking bench for mvm_axis_loader
module tb_mvm_axis_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [8:0] cmd_addr = '0;
  logic [5:0] cmd_dpe = '0;
  logic [6:0] cmd_len = '0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [511:0] wr_data = '0;
  logic axis_rx_tvalid;
  logic [511:0] axis_rx_tdata;
  logic [74:0] axis_rx_tuser;
  logic axis_rx_tlast;
  logic axis_rx_tready = 1'b1;
  logic busy;
  logic done;
  int total = 0;
  int bad = 0;
  int first_cyc, last_cyc;

  mvm_axis_loader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_dpe(cmd_dpe), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tdata(axis_rx_tdata), .axis_rx_tuser(axis_rx_tuser),
    .axis_rx_tlast(axis_rx_tlast), .axis_rx_tready(axis_rx_tready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mk(input int k);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = 32'hC0DE_0000 + 32'(k * 16 + i);
    return w;
  endfunction

  function automatic logic [74:0] exp_user(input logic [1:0] op, input logic [8:0] addr, input int dpe0, input int idx);
    logic [74:0] u;
    u = '0;
    u[8:0] = addr;
    u[10:9] = op;
    if (op == 2'b11) u[11 + ((dpe0 + idx) % 64)] = 1'b1;
    return u;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [5:0] dpe, input logic [6:0] len);
    logic r;
    int g;
    cmd_op = op; cmd_addr = addr; cmd_dpe = dpe; cmd_len = len; cmd_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk); r = cmd_ready;
      @(posedge clk); #1; g++;
    end while (!r && g < 20);
    cmd_valid = 1'b0;
    total++;
    if (r !== 1'b1) begin bad++; $display("FAIL cmd_handshake cmd_ready=%b need=1", r); end
  endtask

  task automatic produce(input int n, input int base);
    int k, g;
    logic hs;
    k = 0; g = 0;
    wr_valid = 1'b1; wr_data = mk(base);
    while (k < n && g < 2000) begin
      @(negedge clk); hs = wr_ready;
      @(posedge clk); #1; g++;
      if (hs) begin k++; wr_data = mk(base + k); end
    end
    wr_valid = 1'b0;
  endtask

  task automatic consume(input logic [1:0] op, input logic [8:0] addr, input int dpe0, input int n, input int base, input int mode);
    int idx, cyc;
    logic hold;
    logic [511:0] hd;
    logic [74:0] hu;
    idx = 0; cyc = 0; hold = 1'b0;
    axis_rx_tready = 1'b1;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      if (hold) begin
        total++;
        if (axis_rx_tvalid !== 1'b1 || axis_rx_tdata !== hd || axis_rx_tuser !== hu)
          begin bad++; $display("FAIL hold_stable beat=%0d tvalid=%b tuser=%h need tuser=%h", idx, axis_rx_tvalid, axis_rx_tuser, hu); end
      end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL early_done beat=%0d done=%b need=0", idx, done); end
      if (axis_rx_tvalid && axis_rx_tready) begin
        total++;
        if (axis_rx_tdata !== mk(base + idx)) begin bad++; $display("FAIL tdata beat=%0d got=%h need=%h", idx, axis_rx_tdata[31:0], mk(base + idx) & 512'hFFFF_FFFF); end
        total++;
        if (axis_rx_tuser !== exp_user(op, addr, dpe0, idx)) begin bad++; $display("FAIL tuser beat=%0d got=%h need=%h", idx, axis_rx_tuser, exp_user(op, addr, dpe0, idx)); end
        total++;
        if (axis_rx_tlast !== 1'b1) begin bad++; $display("FAIL tlast beat=%0d got=%b need=1", idx, axis_rx_tlast); end
        if (idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
        hold = 1'b0;
      end else if (axis_rx_tvalid) begin
        hold = 1'b1; hd = axis_rx_tdata; hu = axis_rx_tuser;
      end else hold = 1'b0;
      @(posedge clk); #1; cyc++;
      axis_rx_tready = mode == 0 ? 1'b1 : (cyc % 3 == 0);
    end
    axis_rx_tready = 1'b1;
    total++;
    if (idx != n) begin bad++; $display("FAIL beat_count got=%0d need=%0d", idx, n); end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [8:0] addr, input logic [5:0] dpe, input logic [6:0] len, input int n, input int base, input int mode);
    send_cmd(op, addr, dpe, len);
    fork
      produce(n, base);
      consume(op, addr, int'(dpe), n, base, mode);
    join
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL done_pulse got=%b need=1", done); end
    total++;
    if (busy !== 1'b0 || axis_rx_tvalid !== 1'b0) begin bad++; $display("FAIL after_done busy=%b tvalid=%b need 0 0", busy, axis_rx_tvalid); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%b need=0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({axis_rx_tvalid, axis_rx_tlast, busy, done, wr_ready, cmd_ready} !== 6'b0 || axis_rx_tdata !== '0 || axis_rx_tuser !== '0)
      begin bad++; $display("FAIL reset_state flags=%b need=000000", {axis_rx_tvalid, axis_rx_tlast, busy, done, wr_ready, cmd_ready}); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset cmd_ready=%b busy=%b need 1 0", cmd_ready, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_weight_load;
    run_cmd(2'b11, 9'h001, 6'd0, 7'd64, 64, 0, 0);
    total++;
    if (last_cyc - first_cyc != 63) begin bad++; $display("FAIL consecutive_beats span=%0d need=63", last_cyc - first_cyc); end
  endtask

  task automatic test_wrap;
    run_cmd(2'b11, 9'h0AB, 6'd62, 7'd4, 4, 100, 0);
  endtask

  task automatic test_vec_instr;
    run_cmd(2'b10, 9'h1F0, 6'd7, 7'd5, 1, 110, 0);
    run_cmd(2'b01, 9'h002, 6'd3, 7'd5, 1, 120, 0);
    run_cmd(2'b00, 9'h155, 6'd9, 7'd5, 1, 130, 0);
  endtask

  task automatic test_backpressure;
    run_cmd(2'b11, 9'h100, 6'd10, 7'd8, 8, 140, 1);
  endtask

  task automatic test_len_zero;
    send_cmd(2'b11, 9'h044, 6'd5, 7'd0);
    wr_valid = 1'b1; wr_data = mk(999);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL len0_done got=%b need=1", done); end
    total++;
    if (busy !== 1'b0 || axis_rx_tvalid !== 1'b0 || wr_ready !== 1'b0)
      begin bad++; $display("FAIL len0_idle busy=%b tvalid=%b wr_ready=%b need 0 0 0", busy, axis_rx_tvalid, wr_ready); end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || axis_rx_tvalid !== 1'b0) begin bad++; $display("FAIL len0_after done=%b tvalid=%b need 0 0", done, axis_rx_tvalid); end
    wr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream;
    int k, g;
    logic hs;
    send_cmd(2'b11, 9'h0F0, 6'd20, 7'd10);
    k = 0; g = 0;
    wr_valid = 1'b1; wr_data = mk(200);
    while (k < 3 && g < 50) begin
      @(negedge clk); hs = wr_ready;
      @(posedge clk); #1; g++;
      if (hs) begin k++; wr_data = mk(200 + k); end
    end
    wr_valid = 1'b0;
    total++;
    if (axis_rx_tvalid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL pre_reset tvalid=%b busy=%b need 1 1", axis_rx_tvalid, busy); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({axis_rx_tvalid, axis_rx_tlast, busy, done, wr_ready, cmd_ready} !== 6'b0 || axis_rx_tdata !== '0 || axis_rx_tuser !== '0)
      begin bad++; $display("FAIL async_reset flags=%b need=000000", {axis_rx_tvalid, axis_rx_tlast, busy, done, wr_ready, cmd_ready}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || axis_rx_tvalid !== 1'b0) begin bad++; $display("FAIL post_reset_quiet done=%b tvalid=%b need 0 0", done, axis_rx_tvalid); end
    end
    @(posedge clk); #1;
    run_cmd(2'b11, 9'h033, 6'd40, 7'd2, 2, 300, 0);
  endtask

  initial begin
    test_reset;
    test_weight_load;
    test_wrap;
    test_vec_instr;
    test_backpressure;
    test_len_zero;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
